next_state_sequencer: RTL and testbench
=======================================

NEXT_STATE_SEQUENCER -- requirements
Module: next_state_sequencer

Interface
REQ-001 Parameter RESET_STATE, default 10'd0: microstore address loaded on reset.
REQ-002 Parameter FAULT_STATE, default 10'h3FF: address taken on memory timeout.
REQ-003 Parameter TIMEOUT, default 64: maximum wait cycles for moc; legal range 2..255.
REQ-004 clk  input  1: single clock; all state changes on rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset.
REQ-006 N  input  3: next-state selector from the control register.
REQ-007 inv  input  1: inverts the tested condition (cond or moc).
REQ-008 cr  input  10: constant target address from the control register.
REQ-009 encoder_state  input  10: dispatch address from the instruction encoder.
REQ-010 cond  input  1: condition tester result.
REQ-011 moc  input  1: memory operation complete.
REQ-012 state  output  10: registered current microstore address.
REQ-013 stall  output  1: registered; high while holding in a memory wait.
REQ-014 mem_fault  output  1: registered; one-cycle pulse on timeout.

Function
REQ-015 The sequencer SHALL register next state on every rising clk; decode is combinational from current inputs, one cycle latency.
REQ-016 incr SHALL equal state+1 modulo 1024; 10'h3FF wraps to 10'h000.
REQ-017 t SHALL equal cond XOR inv for N=3, N=5; m SHALL equal moc XOR inv for N=4.
REQ-018 N=0 dispatch: next = encoder_state.
REQ-019 N=1 jump: next = cr.
REQ-020 N=2 continue: next = incr.
REQ-021 N=3 branch: next = cr if t, else incr.
REQ-022 N=4 memory wait: next = cr if m; else hold state and increment wait counter.
REQ-023 N=5 branch-or-dispatch: next = cr if t, else encoder_state.
REQ-024 N=6 call: ret_reg <= incr; next = cr (single-level; a second call overwrites ret_reg).
REQ-025 N=7 return: next = ret_reg; ret_reg unchanged.
REQ-026 Wait counter (8-bit) SHALL clear on any cycle not a held N=4 cycle, including N=4 with m=1.
REQ-027 stall SHALL be 1 in the cycle after any N=4 hold decision, else 0.
REQ-028 If N=4, m=0 and counter = TIMEOUT-1, next SHALL be FAULT_STATE, mem_fault SHALL be 1 next cycle, counter clears, stall 0.
REQ-029 If m=1 in the same cycle the counter reaches TIMEOUT-1, completion SHALL win: next = cr, no fault.
REQ-030 mem_fault SHALL be 0 in all other cycles.
REQ-031 Call to a state whose incr wraps SHALL store 10'h000 in ret_reg.

Reset
REQ-032 While reset=0, asynchronously: state=RESET_STATE, ret_reg=0, counter=0, stall=0, mem_fault=0.
REQ-033 Reset asserted mid-wait SHALL abort the wait with no mem_fault pulse.
REQ-034 First edge after reset release SHALL apply normal decode from RESET_STATE.

Verification
REQ-035 Reset, then N=2 for 3 cycles -> state 0,1,2,3; force state 10'h3FF, N=2 -> 10'h000.
REQ-036 N=3, cr=10'd40, cond=1, inv=0 -> 40; cond=1, inv=1 -> state+1; N=0, encoder_state=10'd77 -> 77.
REQ-037 State 10, N=6, cr=200 -> 200, ret_reg=11; then N=7 -> 11.
REQ-038 N=4, cr=5, moc=0 for 3 cycles then 1 -> state held 3 cycles, stall=1 on those, then 5, stall=0.
REQ-039 N=4, moc=0 held, TIMEOUT=64 -> after 64th decode state=10'h3FF, mem_fault=1 one cycle; repeat with moc=1 on 64th -> cr, no fault.
REQ-040 Drop reset during wait at count 30 -> state=RESET_STATE immediately, stall=0, mem_fault=0, counter restarts at 0.

Source files
------------

// File: rtl/next_state_sequencer.sv
// Microprogram next-state sequencer.
// Each cycle selects the next microstore address from the N selector:
// dispatch, jump, continue, conditional branch, memory wait, branch-or-dispatch,
// single-level call and return. Memory waits are bounded by TIMEOUT cycles,
// after which control is diverted to FAULT_STATE with a one-cycle mem_fault pulse.
module next_state_sequencer #(
  parameter logic [9:0]  RESET_STATE = 10'd0,
  parameter logic [9:0]  FAULT_STATE = 10'h3FF,
  parameter int unsigned TIMEOUT     = 64       // legal range 2..255
) (
  input  logic       clk,
  input  logic       reset,          // asynchronous, active low
  input  logic [2:0] N,
  input  logic       inv,
  input  logic [9:0] cr,
  input  logic [9:0] encoder_state,
  input  logic       cond,
  input  logic       moc,
  output logic [9:0] state,
  output logic       stall,
  output logic       mem_fault
);

  typedef enum logic [2:0] {
    OP_DISPATCH    = 3'd0,
    OP_JUMP        = 3'd1,
    OP_CONTINUE    = 3'd2,
    OP_BRANCH      = 3'd3,
    OP_MEM_WAIT    = 3'd4,
    OP_BRANCH_DISP = 3'd5,
    OP_CALL        = 3'd6,
    OP_RETURN      = 3'd7
  } op_e;

  // Counter value on which a still-pending wait gives up.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  logic [9:0] r_state;
  logic [9:0] r_ret;
  logic [7:0] r_wait_cnt;
  logic       r_stall;
  logic       r_mem_fault;

  op_e        w_op;
  logic [9:0] w_incr;
  logic       w_t;
  logic       w_m;
  logic [9:0] w_next_state;
  logic [9:0] w_next_ret;
  logic       w_hold;
  logic       w_fault;
  logic [7:0] w_next_wait;

  assign w_op   = op_e'(N);
  assign w_incr = r_state + 10'd1;   // 10-bit add wraps 3FF -> 000
  assign w_t    = cond ^ inv;
  assign w_m    = moc ^ inv;

  // Next-state decode from the selector and the current inputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned; otherwise a latch would be inferred.
    w_next_state = r_state;
    w_next_ret   = r_ret;
    w_hold       = 1'b0;
    w_fault      = 1'b0;
    case (w_op)
      OP_DISPATCH:    w_next_state = encoder_state;
      OP_JUMP:        w_next_state = cr;
      OP_CONTINUE:    w_next_state = w_incr;
      OP_BRANCH:      w_next_state = w_t ? cr : w_incr;
      OP_MEM_WAIT: begin
        if (w_m) begin
          // Completion wins even on the last permitted wait cycle.
          w_next_state = cr;
        end else if (r_wait_cnt == LAST_WAIT) begin
          w_next_state = FAULT_STATE;
          w_fault      = 1'b1;
        end else begin
          w_next_state = r_state;
          w_hold       = 1'b1;
        end
      end
      OP_BRANCH_DISP: w_next_state = w_t ? cr : encoder_state;
      OP_CALL: begin
        w_next_ret   = w_incr;
        w_next_state = cr;
      end
      OP_RETURN:      w_next_state = r_ret;
      default:        w_next_state = r_state;
    endcase
  end

  // Wait counter only survives consecutive held memory-wait cycles.
  assign w_next_wait = w_hold ? (r_wait_cnt + 8'd1) : 8'd0;

  // Architectural registers; reset aborts any wait in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RESET_STATE;
      r_ret       <= 10'd0;
      r_wait_cnt  <= 8'd0;
      r_stall     <= 1'b0;
      r_mem_fault <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // decoded from the same pre-edge state, independent of statement order.
      r_state     <= w_next_state;
      r_ret       <= w_next_ret;
      r_wait_cnt  <= w_next_wait;
      r_stall     <= w_hold;
      r_mem_fault <= w_fault;
    end
  end

  assign state     = r_state;
  assign stall     = r_stall;
  assign mem_fault = r_mem_fault;

endmodule

// File: tb/tb_next_state_sequencer.sv
// Self-checking bench for next_state_sequencer: directed scenarios followed by
// randomized selector/condition traffic, all compared against a behavioural model.
module tb_next_state_sequencer;

  localparam int         TIMEOUT = 64;
  localparam logic [9:0] RST_ST  = 10'd0;
  localparam logic [9:0] FLT_ST  = 10'h3FF;

  logic       clk;
  logic       reset;
  logic [2:0] N;
  logic       inv;
  logic [9:0] cr;
  logic [9:0] encoder_state;
  logic       cond;
  logic       moc;
  logic [9:0] state;
  logic       stall;
  logic       mem_fault;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: plain integers, arithmetic modulo 1024.
  int m_state;
  int m_ret;
  int m_waited;   // consecutive cycles spent holding in a memory wait
  int m_stall;
  int m_fault;

  next_state_sequencer #(
    .RESET_STATE(RST_ST),
    .FAULT_STATE(FLT_ST),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .N            (N),
    .inv          (inv),
    .cr           (cr),
    .encoder_state(encoder_state),
    .cond         (cond),
    .moc          (moc),
    .state        (state),
    .stall        (stall),
    .mem_fault    (mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_state  = int'(RST_ST);
    m_ret    = 0;
    m_waited = 0;
    m_stall  = 0;
    m_fault  = 0;
  endtask

  // Apply the sequencing rules to the current inputs to get the next model state.
  task automatic model_step();
    int t, m, incr, nxt;
    t       = int'(cond ^ inv);
    m       = int'(moc ^ inv);
    incr    = (m_state + 1) % 1024;
    nxt     = m_state;
    m_stall = 0;
    m_fault = 0;
    if (N != 3'd4) m_waited = 0;
    case (N)
      3'd0: nxt = int'(encoder_state);
      3'd1: nxt = int'(cr);
      3'd2: nxt = incr;
      3'd3: nxt = t ? int'(cr) : incr;
      3'd4: begin
        if (m == 1) begin
          nxt = int'(cr);
          m_waited = 0;
        end else if (m_waited == TIMEOUT - 1) begin
          nxt = int'(FLT_ST);
          m_fault = 1;
          m_waited = 0;
        end else begin
          m_stall = 1;
          m_waited++;
        end
      end
      3'd5: nxt = t ? int'(cr) : int'(encoder_state);
      3'd6: begin
        m_ret = incr;
        nxt   = int'(cr);
      end
      default: nxt = m_ret;
    endcase
    m_state = nxt;
  endtask

  task automatic drive(input logic [2:0] n, input logic i, input logic [9:0] c,
                       input logic [9:0] e, input logic cd, input logic mc);
    N = n; inv = i; cr = c; encoder_state = e; cond = cd; moc = mc;
  endtask

  // One clock: model advances, DUT sampled 1 ns after the edge.
  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".state"}, int'(state), m_state);
    check({tag, ".stall"}, int'(stall), m_stall);
    check({tag, ".fault"}, int'(mem_fault), m_fault);
  endtask

  initial begin
    reset = 1'b0;
    drive(3'd2, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
    model_reset();
    #12;
    check("rst.state", int'(state), int'(RST_ST));
    check("rst.stall", int'(stall), 0);
    check("rst.fault", int'(mem_fault), 0);
    reset = 1'b1;

    // Continue from reset and wrap at the top of the address space.
    for (int i = 1; i <= 3; i++) begin
      step("cont");
      check("cont.abs", int'(state), i);
    end
    drive(3'd1, 1'b0, 10'h3FF, 10'd0, 1'b0, 1'b0); step("jmp3ff");
    drive(3'd2, 1'b0, 10'd0,   10'd0, 1'b0, 1'b0); step("wrap");
    check("wrap.abs", int'(state), 0);

    // Branch taken, branch inverted (falls through), dispatch.
    drive(3'd3, 1'b0, 10'd40, 10'd0, 1'b1, 1'b0); step("br_t");
    check("br_t.abs", int'(state), 40);
    drive(3'd3, 1'b1, 10'd40, 10'd0, 1'b1, 1'b0); step("br_inv");
    check("br_inv.abs", int'(state), 41);
    drive(3'd0, 1'b0, 10'd0, 10'd77, 1'b0, 1'b0); step("disp");
    check("disp.abs", int'(state), 77);
    drive(3'd5, 1'b0, 10'd300, 10'd12, 1'b0, 1'b0); step("bd_disp");
    check("bd_disp.abs", int'(state), 12);
    drive(3'd5, 1'b1, 10'd300, 10'd12, 1'b0, 1'b0); step("bd_br");
    check("bd_br.abs", int'(state), 300);

    // Call / return, including a call from the wrapping address.
    drive(3'd1, 1'b0, 10'd10,  10'd0, 1'b0, 1'b0); step("to10");
    drive(3'd6, 1'b0, 10'd200, 10'd0, 1'b0, 1'b0); step("call");
    check("call.abs", int'(state), 200);
    drive(3'd7, 1'b0, 10'd0,   10'd0, 1'b0, 1'b0); step("ret");
    check("ret.abs", int'(state), 11);
    drive(3'd1, 1'b0, 10'h3FF, 10'd0, 1'b0, 1'b0); step("to3ff");
    drive(3'd6, 1'b0, 10'd5,   10'd0, 1'b0, 1'b0); step("callwrap");
    drive(3'd7, 1'b0, 10'd0,   10'd0, 1'b0, 1'b0); step("retwrap");
    check("retwrap.abs", int'(state), 0);

    // Short memory wait: three holds, then completion.
    drive(3'd1, 1'b0, 10'd20, 10'd0, 1'b0, 1'b0); step("to20");
    for (int i = 0; i < 3; i++) begin
      drive(3'd4, 1'b0, 10'd5, 10'd0, 1'b0, 1'b0); step("wait");
      check("wait.held", int'(state), 20);
      check("wait.stall", int'(stall), 1);
    end
    drive(3'd4, 1'b0, 10'd5, 10'd0, 1'b0, 1'b1); step("moc");
    check("moc.abs", int'(state), 5);
    check("moc.stall", int'(stall), 0);
    drive(3'd4, 1'b1, 10'd6, 10'd0, 1'b0, 1'b0); step("moc_inv");
    check("moc_inv.abs", int'(state), 6);

    // Timeout: 63 holds, fault on the 64th decode, pulse lasts one cycle.
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      drive(3'd4, 1'b0, 10'd9, 10'd0, 1'b0, 1'b0); step("to_hold");
    end
    check("to_hold.stall", int'(stall), 1);
    step("to_fire");
    check("to_fire.abs", int'(state), int'(FLT_ST));
    check("to_fire.fault", int'(mem_fault), 1);
    check("to_fire.stall", int'(stall), 0);
    drive(3'd2, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0); step("to_after");
    check("to_after.fault", int'(mem_fault), 0);

    // Completion on the last permitted cycle beats the timeout.
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      drive(3'd4, 1'b0, 10'd9, 10'd0, 1'b0, 1'b0); step("late_hold");
    end
    drive(3'd4, 1'b0, 10'd9, 10'd0, 1'b0, 1'b1); step("late_moc");
    check("late_moc.abs", int'(state), 9);
    check("late_moc.fault", int'(mem_fault), 0);

    // Reset mid-wait at count 30: immediate effect, counter restarts.
    drive(3'd1, 1'b0, 10'd100, 10'd0, 1'b0, 1'b0); step("to100");
    for (int i = 0; i < 30; i++) begin
      drive(3'd4, 1'b0, 10'd9, 10'd0, 1'b0, 1'b0); step("pre_rst");
    end
    #1 reset = 1'b0;
    #1;
    model_reset();
    check("midrst.state", int'(state), int'(RST_ST));
    check("midrst.stall", int'(stall), 0);
    check("midrst.fault", int'(mem_fault), 0);
    #1 reset = 1'b1;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      step("post_rst_hold");
    end
    check("post_rst.nofault", int'(mem_fault), 0);
    step("post_rst_fire");
    check("post_rst.fault", int'(mem_fault), 1);

    // Randomized traffic; memory-wait completion is made rare to reach timeouts.
    for (int i = 0; i < 600; i++) begin
      drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 10'($urandom),
            10'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
      if (N == 3'd4 && inv == 1'b1) inv = ($urandom_range(0, 7) == 0);
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
